// File: rtl/apb_uart_fifo_if.sv
// rtl/apb_uart_fifo_if.sv - APB slave bus bundle for apb_uart_fifo
interface apb_uart_fifo_if;
  logic [31:0] i_Paddr;
  logic        i_Psel;
  logic        i_Penable;
  logic        i_Pwrite;
  logic [7:0]  i_Pwdata;
  logic        o_Pready;
  logic [7:0]  o_Prdata;

  modport master (
    output i_Paddr, i_Psel, i_Penable, i_Pwrite, i_Pwdata,
    input  o_Pready, o_Prdata
  );

  modport slave (
    input  i_Paddr, i_Psel, i_Penable, i_Pwrite, i_Pwdata,
    output o_Pready, o_Prdata
  );
endinterface

// File: rtl/apb_uart_fifo.sv
// rtl/apb_uart_fifo.sv - APB UART with TX/RX FIFOs, parity, sticky errors, irq (option: UART_LOOPBACK_EN)
module apb_uart_fifo #(
  parameter int CLK_HZ     = 10_000_000,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           i_Pclk,
  input  logic           i_Presetn,
  apb_uart_fifo_if.slave apb,
  input  logic           i_Rx_Serial,
  output logic           o_Tx_Serial,
  output logic           o_Irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int D0 = (CLK_HZ + 600) / 1200;
  localparam int D1 = (CLK_HZ + 1200) / 2400;
  localparam int D2 = (CLK_HZ + 2400) / 4800;
  localparam int D3 = (CLK_HZ + 4800) / 9600;
  localparam int D4 = (CLK_HZ + 9600) / 19200;
  localparam int D5 = (CLK_HZ + 19200) / 38400;
  localparam int D6 = (CLK_HZ + 28800) / 57600;
  localparam int D7 = (CLK_HZ + 57600) / 115200;
`ifdef UART_LOOPBACK_EN
  localparam logic [7:0] CTRL_MASK = 8'h7F;
`else
  localparam logic [7:0] CTRL_MASK = 8'h3F;
`endif
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  function automatic logic [15:0] div_of(input logic [2:0] sel);
    case (sel)
      3'd0: return 16'(D0);
      3'd1: return 16'(D1);
      3'd2: return 16'(D2);
      3'd3: return 16'(D3);
      3'd4: return 16'(D4);
      3'd5: return 16'(D5);
      3'd6: return 16'(D6);
      default: return 16'(D7);
    endcase
  endfunction

  logic [7:0]           ctrl_q, ctrl_d;
  logic [2:0]           sticky_q, sticky_d;   // {overrun, frame, parity}
  logic [PW-1:0]        tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [PW-1:0]        rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [DATA_BITS-1:0] tx_mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] rx_mem_q [FIFO_DEPTH];
  state_t               tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [15:0]          tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [15:0]          rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]           tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic                 tx_par_q, tx_par_d, tx_par_en_q, tx_par_en_d;
  logic                 tx_two_q, tx_two_d, tx_stop2_q, tx_stop2_d;
  logic                 rx_par_en_q, rx_par_en_d, rx_odd_q, rx_odd_d;
  logic                 rx_bad_q, rx_bad_d;
  logic                 rx_s1_q, rx_s2_q, rx_s3_q;
  logic                 tx_empty, tx_full, rx_empty, rx_full, tx_busy;
  logic                 access, tx_push, tx_pop, rx_push, rx_pop, ctrl_wr, status_rd;
  logic                 tx_tick, rx_tick, rx_mid, tx_line, rx_in;
  logic [2:0]           err_set;
  logic [7:0]           status;
  logic                 unused_bits;

  assign unused_bits = ^{apb.i_Paddr[29:0], apb.i_Pwdata};
  assign access   = apb.i_Psel & apb.i_Penable;
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
  assign tx_busy  = (tx_state_q != S_IDLE);
  assign status   = {tx_busy, sticky_q, rx_full, rx_empty, tx_full, tx_empty};
  assign o_Irq    = !rx_empty || (sticky_q != 3'b000);

`ifdef UART_LOOPBACK_EN
  assign rx_in       = ctrl_q[6] ? tx_line : i_Rx_Serial;
  assign o_Tx_Serial = ctrl_q[6] ? 1'b1 : tx_line;
`else
  assign rx_in       = i_Rx_Serial;
  assign o_Tx_Serial = tx_line;
`endif

  // APB decode: ready/wait states, read mux, push/pop and register strobes
  always_comb begin
    apb.o_Pready = 1'b0;
    apb.o_Prdata = 8'h00;
    tx_push = 1'b0;
    rx_pop = 1'b0;
    ctrl_wr = 1'b0;
    status_rd = 1'b0;
    if (access) begin
      case (apb.i_Paddr[31:30])
        2'b00: begin
          apb.o_Pready = 1'b1;
          ctrl_wr = apb.i_Pwrite;
          status_rd = !apb.i_Pwrite;
          if (!apb.i_Pwrite) apb.o_Prdata = status;
        end
        2'b01: begin
          // a pop in the same cycle frees the slot, so a full FIFO need not stall
          apb.o_Pready = !apb.i_Pwrite || !tx_full || tx_pop;
          tx_push = apb.i_Pwrite && apb.o_Pready;
        end
        2'b10: begin
          apb.o_Pready = apb.i_Pwrite || !rx_empty;
          rx_pop = !apb.i_Pwrite && !rx_empty;
          if (rx_pop) apb.o_Prdata = 8'(rx_mem_q[rx_rd_q[AW-1:0]]);
        end
        default: begin
          apb.o_Pready = 1'b1;
          if (!apb.i_Pwrite) apb.o_Prdata = ctrl_q;
        end
      endcase
    end
  end

  // Register, pointer and sticky-flag next state; error set wins over read-clear
  always_comb begin
    ctrl_d   = ctrl_wr ? (apb.i_Pwdata & CTRL_MASK) : ctrl_q;
    sticky_d = (status_rd ? 3'b000 : sticky_q) | err_set;
    tx_wr_d  = tx_wr_q + PW'(tx_push);
    tx_rd_d  = tx_rd_q + PW'(tx_pop);
    rx_wr_d  = rx_wr_q + PW'(rx_push);
    rx_rd_d  = rx_rd_q + PW'(rx_pop);
  end

  // TX next state: frame settings captured when a byte is taken from the FIFO
  always_comb begin
    tx_state_d = tx_state_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_par_en_d = tx_par_en_q;
    tx_two_d   = tx_two_q;
    tx_stop2_d = tx_stop2_q;
    tx_pop     = 1'b0;
    tx_tick    = (tx_cnt_q == tx_div_q - 16'd1);
    tx_cnt_d   = tx_tick ? 16'd0 : tx_cnt_q + 16'd1;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = 16'd0;
        if (!tx_empty) begin
          tx_pop      = 1'b1;
          tx_shift_d  = tx_mem_q[tx_rd_q[AW-1:0]];
          tx_par_d    = (^tx_mem_q[tx_rd_q[AW-1:0]]) ^ ctrl_q[4];
          tx_div_d    = div_of(ctrl_q[2:0]);
          tx_par_en_d = ctrl_q[3];
          tx_two_d    = ctrl_q[5];
          tx_stop2_d  = 1'b0;
          tx_bit_d    = 3'd0;
          tx_state_d  = S_START;
        end
      end
      S_START: if (tx_tick) tx_state_d = S_DATA;
      S_DATA: if (tx_tick) begin
        tx_shift_d = tx_shift_q >> 1;
        tx_bit_d   = tx_bit_q + 3'd1;
        if (tx_bit_q == LAST_BIT) tx_state_d = tx_par_en_q ? S_PARITY : S_STOP;
      end
      S_PARITY: if (tx_tick) tx_state_d = S_STOP;
      default: if (tx_tick) begin
        if (tx_two_q && !tx_stop2_q) tx_stop2_d = 1'b1;
        else tx_state_d = S_IDLE;
      end
    endcase
  end

  // TX line drive from the current state
  always_comb begin
    case (tx_state_q)
      S_START:  tx_line = 1'b0;
      S_DATA:   tx_line = tx_shift_q[0];
      S_PARITY: tx_line = tx_par_q;
      default:  tx_line = 1'b1;
    endcase
  end

  // RX next state: mid-bit sampling, errors and overrun resolved at the stop bit
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_div_d    = rx_div_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_par_en_d = rx_par_en_q;
    rx_odd_d    = rx_odd_q;
    rx_bad_d    = rx_bad_q;
    rx_push     = 1'b0;
    err_set     = 3'b000;
    rx_tick     = (rx_cnt_q == rx_div_q - 16'd1);
    rx_mid      = (rx_cnt_q == (rx_div_q >> 1));
    rx_cnt_d    = rx_cnt_q + 16'd1;
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = 16'd0;
        if (rx_s3_q && !rx_s2_q) begin
          rx_div_d    = div_of(ctrl_q[2:0]);
          rx_par_en_d = ctrl_q[3];
          rx_odd_d    = ctrl_q[4];
          rx_bad_d    = 1'b0;
          rx_bit_d    = 3'd0;
          rx_state_d  = S_START;
        end
      end
      S_START: if (rx_mid) begin
        rx_cnt_d   = 16'd0;
        rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_tick) begin
        rx_cnt_d   = 16'd0;
        rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == LAST_BIT) rx_state_d = rx_par_en_q ? S_PARITY : S_STOP;
      end
      S_PARITY: if (rx_tick) begin
        rx_cnt_d   = 16'd0;
        rx_bad_d   = rx_s2_q != ((^rx_shift_q) ^ rx_odd_q);
        rx_state_d = S_STOP;
      end
      default: if (rx_tick) begin
        rx_state_d = S_IDLE;
        err_set[0] = rx_bad_q;
        err_set[1] = !rx_s2_q;
        if (!rx_bad_q && rx_s2_q) begin
          err_set[2] = rx_full;
          rx_push    = !rx_full;
        end
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge i_Pclk) begin
    if (!i_Presetn) begin
      ctrl_q <= 8'h07;       sticky_q <= '0;
      tx_wr_q <= '0;         tx_rd_q <= '0;       rx_wr_q <= '0;      rx_rd_q <= '0;
      tx_state_q <= S_IDLE;  tx_cnt_q <= '0;      tx_div_q <= 16'(D7); tx_bit_q <= '0;
      tx_shift_q <= '0;      tx_par_q <= 1'b0;    tx_par_en_q <= 1'b0;
      tx_two_q <= 1'b0;      tx_stop2_q <= 1'b0;
      rx_state_q <= S_IDLE;  rx_cnt_q <= '0;      rx_div_q <= 16'(D7); rx_bit_q <= '0;
      rx_shift_q <= '0;      rx_par_en_q <= 1'b0; rx_odd_q <= 1'b0;   rx_bad_q <= 1'b0;
      rx_s1_q <= 1'b1;       rx_s2_q <= 1'b1;     rx_s3_q <= 1'b1;
    end else begin
      ctrl_q <= ctrl_d;          sticky_q <= sticky_d;
      tx_wr_q <= tx_wr_d;        tx_rd_q <= tx_rd_d;       rx_wr_q <= rx_wr_d;    rx_rd_q <= rx_rd_d;
      tx_state_q <= tx_state_d;  tx_cnt_q <= tx_cnt_d;     tx_div_q <= tx_div_d;  tx_bit_q <= tx_bit_d;
      tx_shift_q <= tx_shift_d;  tx_par_q <= tx_par_d;     tx_par_en_q <= tx_par_en_d;
      tx_two_q <= tx_two_d;      tx_stop2_q <= tx_stop2_d;
      rx_state_q <= rx_state_d;  rx_cnt_q <= rx_cnt_d;     rx_div_q <= rx_div_d;  rx_bit_q <= rx_bit_d;
      rx_shift_q <= rx_shift_d;  rx_par_en_q <= rx_par_en_d; rx_odd_q <= rx_odd_d; rx_bad_q <= rx_bad_d;
      rx_s1_q <= rx_in;          rx_s2_q <= rx_s1_q;       rx_s3_q <= rx_s2_q;
    end
  end

  // FIFO storage; contents beyond the pointers are don't-care so no reset
  always_ff @(posedge i_Pclk) begin
    if (tx_push) tx_mem_q[tx_wr_q[AW-1:0]] <= apb.i_Pwdata[DATA_BITS-1:0];
    if (rx_push) rx_mem_q[rx_wr_q[AW-1:0]] <= rx_shift_q;
  end
endmodule

// File: tb/tb_apb_uart_fifo.sv
// tb/tb_apb_uart_fifo.sv - directed self-checking bench for apb_uart_fifo
`timescale 1ns/1ps
module tb_apb_uart_fifo;
  localparam int BIT = 87;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic rx_line = 1'b1;
  logic tx_line;
  logic irq;
  int   total = 0;
  int   bad = 0;

  apb_uart_fifo_if bus();

  apb_uart_fifo dut (
    .i_Pclk(clk), .i_Presetn(rstn), .apb(bus),
    .i_Rx_Serial(rx_line), .o_Tx_Serial(tx_line), .o_Irq(irq)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic apb_xfer(input logic [1:0] a, input logic wr, input logic [7:0] wd,
                          output logic [7:0] rd, output int waits);
    @(posedge clk); #1;
    bus.i_Paddr = {a, 30'h1234_567};
    bus.i_Pwrite = wr;
    bus.i_Pwdata = wd;
    bus.i_Psel = 1'b1;
    bus.i_Penable = 1'b0;
    @(posedge clk); #1;
    bus.i_Penable = 1'b1;
    waits = 0;
    rd = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.o_Pready) begin
        rd = bus.o_Prdata;
        break;
      end
      waits++;
      if (waits > 20000) begin
        chk("apb_timeout", 32'(waits), 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
    bus.i_Psel = 1'b0;
    bus.i_Penable = 1'b0;
  endtask

  task automatic send_bit(input logic v);
    rx_line = v;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pen, input bit pbit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (pen) send_bit(pbit);
    send_bit(1'b1);
  endtask

  initial begin
    logic [7:0] rd;
    logic [7:0] exp_d;
    logic [7:0] rx_bytes [5];
    int w;
    bit found;
    bus.i_Paddr = '0; bus.i_Psel = 1'b0; bus.i_Penable = 1'b0;
    bus.i_Pwrite = 1'b0; bus.i_Pwdata = '0;
    rx_bytes[0] = 8'hA1; rx_bytes[1] = 8'h3C; rx_bytes[2] = 8'h5A;
    rx_bytes[3] = 8'hF0; rx_bytes[4] = 8'h0F;

    // reset for two clocks
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_tx", tx_line, 1'b1);
    chk("rst_irq", irq, 1'b0);
    chk("rst_pready", bus.o_Pready, 1'b0);
    apb_xfer(2'b00, 1'b0, 8'h00, rd, w);
    chk("rst_status", rd, 8'h05);
    apb_xfer(2'b11, 1'b0, 8'h00, rd, w);
    chk("rst_ctrl", rd, 8'h07);

    // reserved CTRL bits read back zero
    apb_xfer(2'b00, 1'b1, 8'hFF, rd, w);
    apb_xfer(2'b11, 1'b0, 8'h00, rd, w);
`ifdef UART_LOOPBACK_EN
    chk("ctrl_mask", rd, 8'h7F);
`else
    chk("ctrl_mask", rd, 8'h3F);
`endif
    apb_xfer(2'b00, 1'b1, 8'h07, rd, w);

    // transmit 0xD6 at 87 clocks per bit, LSB first
    apb_xfer(2'b01, 1'b1, 8'hD6, rd, w);
    chk("tx_push_wait", 32'(w), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (tx_line === 1'b0) found = 1'b1;
    end
    chk("tx_start_seen", found, 1'b1);
    repeat (43) @(negedge clk);
    chk("tx_start_bit", tx_line, 1'b0);
    exp_d = 8'hD6;
    for (int i = 0; i < 8; i++) begin
      repeat (BIT) @(negedge clk);
      chk($sformatf("tx_data%0d", i), tx_line, exp_d[i]);
    end
    repeat (BIT) @(negedge clk);
    chk("tx_stop_bit", tx_line, 1'b1);
    repeat (60) @(negedge clk);

    // blocking read of an empty RX FIFO completes when 0x53 arrives
    fork
      send_frame(8'h53, 1'b0, 1'b0);
      apb_xfer(2'b10, 1'b0, 8'h00, rd, w);
    join
    chk("rx_data", rd, 8'h53);
    chk_rng("rx_block_waits", w, 800, 860);
    apb_xfer(2'b00, 1'b0, 8'h00, rd, w);
    chk("rx_status_after", rd, 8'h05);

    // parity enabled even, byte arrives with odd parity
    apb_xfer(2'b00, 1'b1, 8'h0F, rd, w);
    apb_xfer(2'b11, 1'b0, 8'h00, rd, w);
    chk("ctrl_0f", rd, 8'h0F);
    send_frame(8'h53, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    chk("par_irq", irq, 1'b1);
    apb_xfer(2'b00, 1'b0, 8'h00, rd, w);
    chk("par_status", rd, 8'h15);
    apb_xfer(2'b00, 1'b0, 8'h00, rd, w);
    chk("par_status_clr", rd, 8'h05);
    @(negedge clk);
    chk("par_irq_clr", irq, 1'b0);

    // overrun: five frames into a four-entry FIFO
    apb_xfer(2'b00, 1'b1, 8'h07, rd, w);
    for (int i = 0; i < 5; i++) send_frame(rx_bytes[i], 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("ovr_irq", irq, 1'b1);
    apb_xfer(2'b00, 1'b0, 8'h00, rd, w);
    chk("ovr_status", rd, 8'h49);
    for (int i = 0; i < 4; i++) begin
      apb_xfer(2'b10, 1'b0, 8'h00, rd, w);
      chk($sformatf("ovr_rd%0d", i), rd, rx_bytes[i]);
    end
    apb_xfer(2'b00, 1'b0, 8'h00, rd, w);
    chk("ovr_status_end", rd, 8'h05);

    // TX FIFO fill: first byte goes straight to the shifter, four fill the FIFO
    for (int i = 0; i < 5; i++) begin
      apb_xfer(2'b01, 1'b1, 8'(8'h10 + i), rd, w);
      chk($sformatf("fill_wait%0d", i), 32'(w), 32'd0);
    end
    apb_xfer(2'b00, 1'b0, 8'h00, rd, w);
    chk("fill_status", rd, 8'h86);
    apb_xfer(2'b01, 1'b1, 8'h20, rd, w);
    chk_rng("full_stall_waits", w, 830, 880);

    // reset mid-transmission aborts everything
    @(posedge clk); #1 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("abort_tx", tx_line, 1'b1);
    apb_xfer(2'b00, 1'b0, 8'h00, rd, w);
    chk("abort_status", rd, 8'h05);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
